// File: rtl/core_pkg.sv
// Shared core definitions: control-vector layout, ALU op codes
// and architectural constants used across pipeline stages.
package core_pkg;

  localparam int CTRL_W = 9;

  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUOP    = 0;
  localparam int ALUOP_W       = 3;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_RTYPE = 3'd7
  } aluOp_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a valid load in EX whose destination
// is read by the instruction currently in ID.
import core_pkg::*;

module load_use_detect #(
  parameter int RW = 5
) (
  input  logic              idExValid,
  input  logic [CTRL_W-1:0] idExCtrl,
  input  logic [RW-1:0]     idExRt,
  input  logic [RW-1:0]     ifIdRs,
  input  logic [RW-1:0]     ifIdRt,
  input  logic              ifIdUsesRt,
  output logic              hazard
);

  logic rtNonZero;
  logic rsMatch;
  logic rtMatch;

  assign rtNonZero = idExRt != RW'(REG_ZERO);
  assign rsMatch   = idExRt == ifIdRs;
  assign rtMatch   = ifIdUsesRt && (idExRt == ifIdRt);

  assign hazard = idExValid
               && idExCtrl[CTRL_MEMREAD]
               && rtNonZero
               && (rsMatch || rtMatch);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// WB write-through on capture and a saturating bubble counter.
import core_pkg::*;

module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [RW-1:0]     IfId_rs_i,
  input  logic [RW-1:0]     IfId_rt_i,
  input  logic [RW-1:0]     IfId_rd_i,
  input  logic              IfId_usesRt_i,
  input  logic [CTRL_W-1:0] Ctrl_i,
  input  logic [DW-1:0]     RsData_i,
  input  logic [DW-1:0]     RtData_i,
  input  logic [DW-1:0]     Imm_i,
  input  logic [RW-1:0]     MemWb_rd_i,
  input  logic              MemWb_Wb_i,
  input  logic [DW-1:0]     MemWb_data_i,
  input  logic              Flush_i,
  input  logic              Stall_i,
  output logic              Hazard_o,
  output logic [CTRL_W-1:0] IdEx_ctrl_o,
  output logic              IdEx_valid_o,
  output logic [RW-1:0]     IdEx_rs_o,
  output logic [RW-1:0]     IdEx_rt_o,
  output logic [RW-1:0]     IdEx_rd_o,
  output logic [DW-1:0]     IdEx_rsData_o,
  output logic [DW-1:0]     IdEx_rtData_o,
  output logic [DW-1:0]     IdEx_imm_o,
  output logic [CW-1:0]     BubbleCnt_o
);

  logic          bubble;
  logic          wbHit;
  logic          rsWt;
  logic          rtWt;
  logic [DW-1:0] rsIn;
  logic [DW-1:0] rtIn;

  load_use_detect #(.RW(RW)) uLud (
    .idExValid  (IdEx_valid_o),
    .idExCtrl   (IdEx_ctrl_o),
    .idExRt     (IdEx_rt_o),
    .ifIdRs     (IfId_rs_i),
    .ifIdRt     (IfId_rt_i),
    .ifIdUsesRt (IfId_usesRt_i),
    .hazard     (Hazard_o)
  );

  assign bubble = Flush_i || Hazard_o;

  // r0 writes are architecturally dropped, so never bypass them
  assign wbHit = MemWb_Wb_i && (MemWb_rd_i != RW'(REG_ZERO));
  assign rsWt  = wbHit && (MemWb_rd_i == IfId_rs_i);
  assign rtWt  = wbHit && (MemWb_rd_i == IfId_rt_i);
  assign rsIn  = rsWt ? MemWb_data_i : RsData_i;
  assign rtIn  = rtWt ? MemWb_data_i : RtData_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      IdEx_ctrl_o   <= '0;
      IdEx_valid_o  <= 1'b0;
      IdEx_rs_o     <= '0;
      IdEx_rt_o     <= '0;
      IdEx_rd_o     <= '0;
      IdEx_rsData_o <= '0;
      IdEx_rtData_o <= '0;
      IdEx_imm_o    <= '0;
      BubbleCnt_o   <= '0;
    end else if (Stall_i) begin
      BubbleCnt_o   <= BubbleCnt_o;
    end else if (bubble) begin
      IdEx_ctrl_o   <= '0;
      IdEx_valid_o  <= 1'b0;
      IdEx_rs_o     <= '0;
      IdEx_rt_o     <= '0;
      IdEx_rd_o     <= '0;
      IdEx_rsData_o <= '0;
      IdEx_rtData_o <= '0;
      IdEx_imm_o    <= '0;
      if (BubbleCnt_o != '1) begin
        BubbleCnt_o <= BubbleCnt_o + CW'(1);
      end
    end else begin
      IdEx_ctrl_o   <= Ctrl_i;
      IdEx_valid_o  <= 1'b1;
      IdEx_rs_o     <= IfId_rs_i;
      IdEx_rt_o     <= IfId_rt_i;
      IdEx_rd_o     <= IfId_rd_i;
      IdEx_rsData_o <= rsIn;
      IdEx_rtData_o <= rtIn;
      IdEx_imm_o    <= Imm_i;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: behavioural model compared every
// cycle plus hand-computed literal checks on key scenarios.
import core_pkg::*;

module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [RW-1:0]     ifRs, ifRt, ifRd;
  logic              usesRt;
  logic [CTRL_W-1:0] ctrl;
  logic [DW-1:0]     rsData, rtData, imm;
  logic [RW-1:0]     wbRd;
  logic              wbEn;
  logic [DW-1:0]     wbData;
  logic              flush, stall;

  logic              hazard;
  logic [CTRL_W-1:0] exCtrl;
  logic              exValid;
  logic [RW-1:0]     exRs, exRt, exRd;
  logic [DW-1:0]     exRsD, exRtD, exImm;
  logic [CW-1:0]     cnt;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .IfId_rs_i     (ifRs),
    .IfId_rt_i     (ifRt),
    .IfId_rd_i     (ifRd),
    .IfId_usesRt_i (usesRt),
    .Ctrl_i        (ctrl),
    .RsData_i      (rsData),
    .RtData_i      (rtData),
    .Imm_i         (imm),
    .MemWb_rd_i    (wbRd),
    .MemWb_Wb_i    (wbEn),
    .MemWb_data_i  (wbData),
    .Flush_i       (flush),
    .Stall_i       (stall),
    .Hazard_o      (hazard),
    .IdEx_ctrl_o   (exCtrl),
    .IdEx_valid_o  (exValid),
    .IdEx_rs_o     (exRs),
    .IdEx_rt_o     (exRt),
    .IdEx_rd_o     (exRd),
    .IdEx_rsData_o (exRsD),
    .IdEx_rtData_o (exRtD),
    .IdEx_imm_o    (exImm),
    .BubbleCnt_o   (cnt)
  );

  always #5 clk = ~clk;

  // Model: what ID/EX must hold, derived from the stage rules
  int unsigned mCtrl, mValid, mRs, mRt, mRd, mRsD, mRtD, mImm, mCnt;

  function automatic bit mHaz();
    return mValid == 1 && mCtrl[CTRL_MEMREAD] && mRt != 0 &&
      (mRt == ifRs || (usesRt && mRt == ifRt));
  endfunction

  always @(posedge clk) begin
    bit h;
    h = mHaz();
    if (rst) begin
      {mCtrl, mValid, mRs, mRt, mRd} = '0;
      {mRsD, mRtD, mImm, mCnt} = '0;
    end else if (stall) begin
      mCnt = mCnt;
    end else if (flush || h) begin
      {mCtrl, mValid, mRs, mRt, mRd} = '0;
      {mRsD, mRtD, mImm} = '0;
      if (mCnt < CMAX) mCnt = mCnt + 1;
    end else begin
      mCtrl  = ctrl;
      mValid = 1;
      mRs    = ifRs;
      mRt    = ifRt;
      mRd    = ifRd;
      mRsD   = (wbEn && wbRd != 0 && wbRd == ifRs) ? wbData : rsData;
      mRtD   = (wbEn && wbRd != 0 && wbRd == ifRt) ? wbData : rtData;
      mImm   = imm;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("m.hazard", 32'(hazard), 32'(mHaz()));
        chk("m.ctrl",   32'(exCtrl), mCtrl);
        chk("m.valid",  32'(exValid), mValid);
        chk("m.rs",     32'(exRs), mRs);
        chk("m.rt",     32'(exRt), mRt);
        chk("m.rd",     32'(exRd), mRd);
        chk("m.rsData", exRsD, mRsD);
        chk("m.rtData", exRtD, mRtD);
        chk("m.imm",    exImm, mImm);
        chk("m.cnt",    32'(cnt), mCnt);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setId(logic [RW-1:0] s, logic [RW-1:0] t,
                       logic [RW-1:0] d, logic u,
                       logic [CTRL_W-1:0] c, logic [DW-1:0] sd,
                       logic [DW-1:0] td, logic [DW-1:0] im);
    ifRs = s; ifRt = t; ifRd = d; usesRt = u;
    ctrl = c; rsData = sd; rtData = td; imm = im;
  endtask

  logic [CTRL_W-1:0] cLw, cAdd, cAddi;

  initial begin
    cLw   = '0;
    cLw[CTRL_REGWRITE] = 1'b1;
    cLw[CTRL_MEMTOREG] = 1'b1;
    cLw[CTRL_MEMREAD]  = 1'b1;
    cLw[CTRL_ALUSRC]   = 1'b1;
    cAdd  = '0;
    cAdd[CTRL_REGWRITE] = 1'b1;
    cAdd[CTRL_REGDST]   = 1'b1;
    cAdd[CTRL_ALUOP +: ALUOP_W] = ALU_RTYPE;
    cAddi = '0;
    cAddi[CTRL_REGWRITE] = 1'b1;
    cAddi[CTRL_ALUSRC]   = 1'b1;

    fork compareLoop(); join_none

    rst = 1'b1; stall = 1'b1; flush = 1'b0;
    wbEn = 1'b1; wbRd = 5'd3; wbData = 32'h5555_AAAA;
    setId(5'd3, 5'd7, 5'd9, 1'b1, cLw, 32'h11, 32'h22, 32'h33);
    tick();
    armed = 1'b1;
    tick();
    chk("rst.valid", 32'(exValid), 32'd0);
    chk("rst.ctrl", 32'(exCtrl), 32'd0);
    chk("rst.rsData", exRsD, 32'd0);
    chk("rst.cnt", 32'(cnt), 32'd0);
    chk("rst.hazard", 32'(hazard), 32'd0);

    rst = 1'b0; stall = 1'b0; wbEn = 1'b0;
    setId(5'd29, 5'd8, 5'd0, 1'b0, cLw, 32'd100, 32'd0, 32'd4);
    tick();
    chk("lw.valid", 32'(exValid), 32'd1);
    chk("lw.rt", 32'(exRt), 32'd8);

    setId(5'd8, 5'd3, 5'd9, 1'b1, cAdd, 32'd0, 32'd7, 32'd0);
    #1 chk("lu.hazard", 32'(hazard), 32'd1);
    tick();
    chk("lu.bubValid", 32'(exValid), 32'd0);
    chk("lu.bubCtrl", 32'(exCtrl), 32'd0);
    chk("lu.cnt", 32'(cnt), 32'd1);
    #1 chk("lu.hazOff", 32'(hazard), 32'd0);
    tick();
    chk("lu.addRs", 32'(exRs), 32'd8);
    chk("lu.addValid", 32'(exValid), 32'd1);

    setId(5'd29, 5'd8, 5'd0, 1'b0, cLw, 32'd100, 32'd0, 32'd8);
    tick();
    setId(5'd4, 5'd8, 5'd0, 1'b0, cAddi, 32'd1, 32'd2, 32'd9);
    #1 chk("nort.hazard", 32'(hazard), 32'd0);
    tick();
    chk("nort.ctrl", 32'(exCtrl), 32'(cAddi));
    chk("nort.cnt", 32'(cnt), 32'd1);

    wbEn = 1'b1; wbRd = 5'd5; wbData = 32'hDEAD_BEEF;
    setId(5'd5, 5'd6, 5'd10, 1'b1, cAdd, 32'h0, 32'h66, 32'h0);
    tick();
    chk("wt.rs", exRsD, 32'hDEAD_BEEF);
    chk("wt.rtKeep", exRtD, 32'h66);
    wbRd = 5'd0;
    setId(5'd0, 5'd7, 5'd10, 1'b1, cAdd, 32'h1234, 32'h77, 32'h0);
    tick();
    chk("wt.r0", exRsD, 32'h1234);
    wbRd = 5'd7;
    setId(5'd1, 5'd7, 5'd10, 1'b1, cAdd, 32'h1, 32'h0, 32'h0);
    tick();
    chk("wt.rt", exRtD, 32'hDEAD_BEEF);
    wbEn = 1'b0;

    stall = 1'b1; flush = 1'b1;
    setId(5'd2, 5'd3, 5'd4, 1'b1, cAddi, 32'h99, 32'h98, 32'h97);
    tick();
    tick();
    chk("stall.rtData", exRtD, 32'hDEAD_BEEF);
    chk("stall.cnt", 32'(cnt), 32'd1);
    stall = 1'b0;
    tick();
    chk("flush.valid", 32'(exValid), 32'd0);
    chk("flush.cnt", 32'(cnt), 32'd2);

    for (int i = 0; i < 20; i++) tick();
    chk("sat.cnt", 32'(cnt), 32'd15);

    stall = 1'b1; rst = 1'b1;
    tick();
    chk("rstStall.cnt", 32'(cnt), 32'd0);
    chk("rstStall.valid", 32'(exValid), 32'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    chk("post.imm", exImm, 32'h97);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, sitting directly upstream of the EX-stage forwarding unit and ALU.
- Latches decoded control, operand data, immediate and register numbers from ID. Detects load-use hazards and inserts bubbles.
- Applies same-cycle WB-to-ID write-through on operand capture.
- Drives the IdEx_rs/rt fields consumed by forwarding and exposes a saturating bubble counter.

Parameters:
- DW, 32, data width
- RW, 5, register-number width
- CW, 16, bubble-counter width

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- IfId_rs_i  in  RW  rs field of instruction in ID
- IfId_rt_i  in  RW  rt field in ID
- IfId_rd_i  in  RW  rd field in ID
- IfId_usesRt_i  in  1  ID instruction reads rt as a source
- Ctrl_i  in  9  {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[2:0]}
- RsData_i  in  DW  register-file rs read data
- RtData_i  in  DW  register-file rt read data
- Imm_i  in  DW  sign-extended immediate
- MemWb_rd_i  in  RW  WB destination register
- MemWb_Wb_i  in  1  WB RegWrite
- MemWb_data_i  in  DW  WB write data
- Flush_i  in  1  branch/jump taken; squash ID instruction
- Stall_i  in  1  external freeze (memory wait); hold ID/EX contents
- Hazard_o  out  1  load-use stall request to PC and IF/ID (combinational)
- IdEx_ctrl_o  out  9  registered control
- IdEx_valid_o  out  1  registered instruction-valid
- IdEx_rs_o  out  RW  registered rs number
- IdEx_rt_o  out  RW  registered rt number
- IdEx_rd_o  out  RW  registered rd number
- IdEx_rsData_o  out  DW  registered rs operand
- IdEx_rtData_o  out  DW  registered rt operand
- IdEx_imm_o  out  DW  registered immediate
- BubbleCnt_o  out  CW  count of inserted bubbles, saturating

Behaviour:
- Reset: all registered outputs 0 at the first posedge with rst_i=1. Reset overrides every other input, including Stall_i.
- Hazard_o = IdEx_valid_o & IdEx_ctrl_o.MemRead & (IdEx_rt_o != 0) & ((IdEx_rt_o == IfId_rs_i) | (IfId_usesRt_i & (IdEx_rt_o == IfId_rt_i))). It is purely combinational from the registered state and IF/ID fields.
- Per-edge action, by priority:
  - rst_i: reset.
  - Stall_i: HOLD. Every register keeps its value and BubbleCnt_o does not change.
  - Flush_i or Hazard_o: BUBBLE. ctrl=0, valid=0, register numbers=0, data=0. BubbleCnt_o increments by 1.
  - Otherwise: LOAD. ID values are captured and valid=1.
- Flush_i and Hazard_o asserted together give one bubble, and the counter increments once.
- Write-through on LOAD: if MemWb_Wb_i & (MemWb_rd_i != 0) & (MemWb_rd_i == IfId_rs_i), then rsData is captured from MemWb_data_i instead of RsData_i. The same rule applies independently to rt.
- Register 0 is never bypassed.
- BubbleCnt_o saturates at 2^CW-1 and does not wrap.
- Latency: exactly 1 cycle from ID inputs to outputs on LOAD.
- A bubble has valid=0 and RegWrite=0, so downstream forwarding never matches it: rd=0 and Wb=0.
- The hazard holds for one cycle only. After the bubble, IdEx MemRead=0, so Hazard_o deasserts and the held ID instruction loads next cycle.
- While Stall_i holds, Hazard_o may remain high. The upstream stages stall anyway, so this is not an error.

Decomposition:
- Shared package (core_pkg) holds:
  - control-vector bit indices: CTRL_REGWRITE .. CTRL_ALUOP
  - CTRL_W = 9
  - ALUOp encodings
  - REG_ZERO constant
- One natural sub-module: load_use_detect, a combinational Hazard_o computation reused by the IF/ID stall logic.
- The write-through mux stays inline.

Test Plan:
- Reset: drive arbitrary inputs, rst_i=1 for 2 cycles -> all outputs 0, Hazard_o=0, BubbleCnt_o=0.
- Load-use: lw $8 loaded (MemRead=1, rt=8). Next ID instruction add $9,$8,$3 -> Hazard_o=1 that cycle. Next edge gives a bubble (ctrl=0, valid=0), BubbleCnt_o=1. Following edge loads the add with rs=8.
- rt not used: lw rt=8, then ID addi $8 with IfId_rt_i=8, usesRt=0 -> Hazard_o=0, normal LOAD.
- Write-through: MemWb_Wb_i=1, MemWb_rd_i=5, data=0xDEADBEEF, IfId_rs_i=5, RsData_i=0x0 -> IdEx_rsData_o=0xDEADBEEF. Same with rd=0 -> RsData_i is taken.
- Stall vs flush: Stall_i=1 and Flush_i=1 together -> contents held, counter unchanged. Drop Stall_i with Flush_i=1 -> bubble, counter +1.
- Saturation: CW=4, force 20 bubbles -> BubbleCnt_o stops at 15. Reset mid-stall -> 0 on next edge.
